// File: rtl/chaos_plot_display.sv
// chaos_plot_display
// Scrolling multi-channel logistic-map trajectory plotter for the VGA path.
// Keeps the newest DEPTH samples of each channel in a circular history and
// draws each one as a coloured horizontal band, two pixel clocks behind the
// row/col it was asked for. Arrow keys pan the plot origin once per blanking.
// Build option: define CHAOS_PLOT_GRID_EN to draw a 64-pixel blue grid
// behind the traces inside the plot window.
module chaos_plot_display #(
  parameter int XW        = 17,
  parameter int SHIFT     = 8,
  parameter int DEPTH     = 64,
  parameter int CHANNELS  = 2,
  parameter int XSCALE    = 2,
  parameter int THICK     = 10,
  parameter int STEP      = 2,
  parameter int ORIGIN_X0 = 300,
  parameter int ORIGIN_Y0 = 200
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [9:0]    row,
  input  logic [9:0]    col,
  input  logic          vnotactive,
  input  logic          color,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          sample_valid,
  input  logic [1:0]    sample_ch,
  input  logic [XW-1:0] sample_data,
  output logic          sample_ready,
  output logic          red,
  output logic          green,
  output logic          blue
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [9:0]  STEP_V   = 10'(STEP);
  localparam logic [2:0]  CH_LIMIT = 3'(CHANNELS);
  localparam logic [10:0] DEPTH_V  = 11'(DEPTH);
  localparam logic [10:0] THICK_V  = 11'(THICK);

  // ---------------------------------------------------------------------------
  // Pan FSM
  //   state     | meaning
  //   PAN_IDLE  | active video, waiting for the next blanking interval
  //   PAN_ARMED | in blanking, no move made yet; keys are applied here
  //   PAN_MOVED | in blanking, move already made; wait for active video
  //   (spare)   | unused code, recovers to PAN_IDLE
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    PAN_IDLE  = 2'd0,
    PAN_ARMED = 2'd1,
    PAN_MOVED = 2'd2,
    PAN_SPARE = 2'd3
  } pan_state_t;

  pan_state_t pan_q, pan_d;
  logic [9:0] origin_x_q, origin_x_d;
  logic [9:0] origin_y_q, origin_y_d;
  logic       key_any;

  assign key_any = !up || !down || !left || !right;

  // Pan state and origin registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pan_q      <= PAN_IDLE;
      origin_x_q <= 10'(ORIGIN_X0);
      origin_y_q <= 10'(ORIGIN_Y0);
    end else begin
      pan_q      <= pan_d;
      origin_x_q <= origin_x_d;
      origin_y_q <= origin_y_d;
    end
  end

  // Pan next-state: at most one step per blanking; up beats down, left beats right.
  always_comb begin
    pan_d      = pan_q;
    origin_x_d = origin_x_q;
    origin_y_d = origin_y_q;
    case (pan_q)
      PAN_IDLE: begin
        if (vnotactive) pan_d = PAN_ARMED;
      end
      PAN_ARMED: begin
        if (!up)         origin_y_d = origin_y_q - STEP_V;
        else if (!down)  origin_y_d = origin_y_q + STEP_V;
        if (!left)       origin_x_d = origin_x_q - STEP_V;
        else if (!right) origin_x_d = origin_x_q + STEP_V;
        if (key_any)          pan_d = PAN_MOVED;
        else if (!vnotactive) pan_d = PAN_IDLE;
      end
      PAN_MOVED: begin
        if (!vnotactive) pan_d = PAN_IDLE;
      end
      default: pan_d = PAN_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample intake: ready only during blanking so the history never changes
  // while a frame is being drawn.
  // ---------------------------------------------------------------------------
  logic sample_ready_q;
  logic accept;

  // Ready follows vnotactive one cycle late.
  always_ff @(posedge CLK) begin
    if (RST) sample_ready_q <= 1'b0;
    else     sample_ready_q <= vnotactive;
  end

  assign sample_ready = sample_ready_q;
  // Samples for channels that are not built are taken and dropped.
  assign accept = sample_valid && sample_ready_q && ({1'b0, sample_ch} < CH_LIMIT);

  // ---------------------------------------------------------------------------
  // Pixel address: column offset into the window and history slot k.
  // ---------------------------------------------------------------------------
  logic [9:0]    dx;
  logic [10:0]   kx;
  logic [AW-1:0] k_idx;
  logic          in_win;

  assign dx     = col - origin_x_q;
  assign kx     = 11'(dx) >> XSCALE;
  assign k_idx  = kx[AW-1:0];
  assign in_win = (col >= origin_x_q) && (kx < DEPTH_V);

  logic [CHANNELS-1:0][XW-1:0] rd_data;
  logic [CHANNELS-1:0]         drawable;

  // Stage-1 pipeline registers.
  logic                        s1_win_q;
  logic [9:0]                  s1_row_q;
  logic [9:0]                  s1_oy_q;
  logic                        s1_color_q;
  logic [CHANNELS-1:0]         s1_draw_q;
  logic [CHANNELS-1:0][XW-1:0] s1_data_q;
  logic [CHANNELS-1:0]         hit;
  logic [10:0]                 row11;

  assign row11 = 11'(s1_row_q);

  // ---------------------------------------------------------------------------
  // Per-channel circular history, read port and band hit test.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [XW-1:0] hist_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [FW-1:0] fill_q;
    logic          wr_en;
    logic [AW-1:0] rd_idx;
    logic [10:0]   top;

    assign wr_en = accept && (sample_ch == 2'(c));

    // Write pointer wraps; fill count saturates at DEPTH.
    always_ff @(posedge CLK) begin
      if (RST) begin
        wp_q   <= '0;
        fill_q <= '0;
      end else if (wr_en) begin
        wp_q <= wp_q + 1'b1;
        if (fill_q != FW'(DEPTH)) fill_q <= fill_q + 1'b1;
      end
    end

    // History storage; stale entries are masked by the fill count, not cleared.
    always_ff @(posedge CLK) begin
      if (wr_en && !RST) hist_q[wp_q] <= sample_data;
    end

    // Slot k=0 is the oldest entry, which sits at the write pointer once full.
    assign rd_idx      = wp_q + k_idx;
    assign rd_data[c]  = hist_q[rd_idx];
    assign drawable[c] = (11'(k_idx) + 11'(fill_q)) >= DEPTH_V;

    // Band spans THICK+1 rows starting at originY + scaled sample.
    assign top    = 11'(s1_oy_q) + 11'(s1_data_q[c] >> SHIFT);
    assign hit[c] = s1_win_q && s1_draw_q[c] && (row11 >= top) && (row11 <= top + THICK_V);
  end

  // Stage 1: capture window flag, row, origin, colour mode and history reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_win_q   <= 1'b0;
      s1_row_q   <= '0;
      s1_oy_q    <= '0;
      s1_color_q <= 1'b0;
      s1_draw_q  <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_win_q   <= in_win;
      s1_row_q   <= row;
      s1_oy_q    <= origin_y_q;
      s1_color_q <= color;
      s1_draw_q  <= drawable;
      s1_data_q  <= rd_data;
    end
  end

`ifdef CHAOS_PLOT_GRID_EN
  logic       s1_grid_q;
  logic [5:0] grid_y;

  // Only the low six bits of the row offset matter for a 64-pixel pitch.
  assign grid_y = row[5:0] - origin_y_q[5:0];

  // Grid-line flag travels with the pixel through stage 1.
  always_ff @(posedge CLK) begin
    if (RST) s1_grid_q <= 1'b0;
    else     s1_grid_q <= (dx[5:0] == 6'd0) || (grid_y == 6'd0);
  end
`endif

  function automatic logic [2:0] chan_rgb(input int c);
    case (c)
      0:       chan_rgb = 3'b100;
      1:       chan_rgb = 3'b010;
      2:       chan_rgb = 3'b001;
      default: chan_rgb = 3'b110;
    endcase
  endfunction

  logic [2:0] base_rgb;
  logic [2:0] rgb_d;
  logic [2:0] rgb_q;

  // Stage 2 colour select: lowest hitting channel wins, then optional inversion.
  always_comb begin
    base_rgb = 3'b111;
`ifdef CHAOS_PLOT_GRID_EN
    if (s1_win_q && s1_grid_q) base_rgb = 3'b001;
`endif
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (hit[c]) base_rgb = chan_rgb(c);
    end
    rgb_d = s1_color_q ? ~base_rgb : base_rgb;
  end

  // Stage 2 register drives the colour pins.
  always_ff @(posedge CLK) begin
    if (RST) rgb_q <= 3'b111;
    else     rgb_q <= rgb_d;
  end

  assign red   = rgb_q[2];
  assign green = rgb_q[1];
  assign blue  = rgb_q[0];

endmodule

// File: tb/tb_chaos_plot_display.sv
// Bench for chaos_plot_display: random pixels and samples checked against a
// queue-based reference of the plot, plus directed band/pan/reset pixels.
module tb_chaos_plot_display;

  localparam int XW = 17, SHIFT = 8, DEPTH = 64, CHANNELS = 2, XSCALE = 2;
  localparam int THICK = 10, STEP = 2, OX0 = 300, OY0 = 200;
`ifdef CHAOS_PLOT_GRID_EN
  localparam logic [2:0] GRIDC = 3'b001;
`else
  localparam logic [2:0] GRIDC = 3'b111;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic [9:0] row, col;
  logic vnotactive, color, up, down, left, right, sample_valid;
  logic [1:0] sample_ch;
  logic [XW-1:0] sample_data;
  logic sample_ready, red, green, blue;

  always #5 CLK = ~CLK;

  chaos_plot_display #(
    .XW(XW), .SHIFT(SHIFT), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .XSCALE(XSCALE),
    .THICK(THICK), .STEP(STEP), .ORIGIN_X0(OX0), .ORIGIN_Y0(OY0)
  ) dut (
    .CLK(CLK), .RST(RST), .row(row), .col(col), .vnotactive(vnotactive),
    .color(color), .up(up), .down(down), .left(left), .right(right),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .sample_ready(sample_ready), .red(red), .green(green), .blue(blue)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: per-channel history as oldest-first queues, plot origin.
  logic [XW-1:0] hist [CHANNELS][$];
  int m_ox, m_oy;
  logic prev_vnot;

  // Pending pushes for the next blanking interval, directed pixels for next active phase.
  logic [1:0]    pend_ch [$];
  logic [XW-1:0] pend_d  [$];
  int            dir_r [$];
  int            dir_c [$];
  logic [2:0]    dir_e [$];

  // Two-deep expectation pipe matching the pixel latency.
  bit         p_chk [2];
  bit         p_dir [2];
  logic [2:0] p_exp [2];
  int         p_r [2];
  int         p_c [2];

  function automatic logic [2:0] pal(input int c);
    case (c)
      0: return 3'b100;
      1: return 3'b010;
      2: return 3'b001;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic [2:0] model_rgb(input int r, input int cl, input logic inv);
    int dx, k, n, top;
    logic [2:0] res;
    res = 3'b111;
    dx = (cl - m_ox) & 1023;
    if (cl >= m_ox && dx / (1 << XSCALE) < DEPTH) begin
      k = dx / (1 << XSCALE);
`ifdef CHAOS_PLOT_GRID_EN
      if (dx % 64 == 0 || ((r - m_oy) & 63) == 0) res = 3'b001;
`endif
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        n = hist[c].size();
        if (k >= DEPTH - n) begin
          top = m_oy + int'(hist[c][k - (DEPTH - n)] / (1 << SHIFT));
          if (r >= top && r <= top + THICK) res = pal(c);
        end
      end
    end
    return inv ? ~res : res;
  endfunction

  task automatic model_push(input logic [1:0] ch, input logic [XW-1:0] d);
    int c;
    c = int'(ch);
    if (c < CHANNELS) begin
      hist[c].push_back(d);
      if (hist[c].size() > DEPTH) void'(hist[c].pop_front());
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) hist[c].delete();
    m_ox = OX0;
    m_oy = OY0;
  endtask

  // One pixel clock: check the pixel issued two cycles ago, then issue a new one.
  task automatic cycle(input int r, input int c, input logic vn, input bit dir, input logic [2:0] dexp);
    @(negedge CLK);
    if (p_chk[1])
      check_val($sformatf("%s r%0d c%0d", p_dir[1] ? "dir_rgb" : "rgb", p_r[1], p_c[1]),
                {red, green, blue}, p_exp[1]);
    check_val("ready", sample_ready, prev_vnot);
    p_chk[1] = p_chk[0]; p_dir[1] = p_dir[0]; p_exp[1] = p_exp[0];
    p_r[1] = p_r[0]; p_c[1] = p_c[0];
    row = 10'(r);
    col = 10'(c);
    vnotactive = vn;
    p_chk[0] = !vn;
    p_dir[0] = dir;
    p_r[0] = r;
    p_c[0] = c;
    p_exp[0] = dir ? dexp : model_rgb(r, c, color);
    prev_vnot = vn;
  endtask

  task automatic add_dir(input int r, input int c, input logic [2:0] e);
    dir_r.push_back(r);
    dir_c.push_back(c);
    dir_e.push_back(e);
  endtask

  task automatic blank_phase(input int nblank, input logic [3:0] keys, input logic inv);
    int i;
    i = 0;
    while (i < nblank || pend_ch.size() > 0) begin
      cycle(1023, 1023, 1'b1, 1'b0, 3'b000);
      if (i == 0) begin
        {up, down, left, right} = keys;
        color = inv;
      end
      if (i >= 2 && pend_ch.size() > 0) begin
        sample_valid = 1'b1;
        sample_ch    = pend_ch.pop_front();
        sample_data  = pend_d.pop_front();
        model_push(sample_ch, sample_data);
      end else begin
        sample_valid = 1'b0;
      end
      i++;
    end
    cycle(1023, 1023, 1'b1, 1'b0, 3'b000);
    sample_valid = 1'b0;
    cycle(1023, 1023, 1'b1, 1'b0, 3'b000);
    if (!keys[3])      m_oy = (m_oy - STEP) & 1023;
    else if (!keys[2]) m_oy = (m_oy + STEP) & 1023;
    if (!keys[1])      m_ox = (m_ox - STEP) & 1023;
    else if (!keys[0]) m_ox = (m_ox + STEP) & 1023;
  endtask

  task automatic active_phase(input int npix);
    int r, c;
    while (dir_r.size() > 0)
      cycle(dir_r.pop_front(), dir_c.pop_front(), 1'b0, 1'b1, dir_e.pop_front());
    for (int p = 0; p < npix; p++) begin
      r = (m_oy - 4 + int'($urandom_range(0, 180))) & 1023;
      c = (m_ox - 8 + int'($urandom_range(0, DEPTH * (1 << XSCALE) + 16))) & 1023;
      cycle(r, c, 1'b0, 1'b0, 3'b000);
    end
  endtask

  task automatic frame(input int npix, input int nblank, input logic [3:0] keys, input logic inv);
    blank_phase(nblank, keys, inv);
    active_phase(npix);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    sample_valid = 1'b0;
    @(negedge CLK);
    check_val("rst_rgb", {red, green, blue}, 3'b111);
    check_val("rst_ready", sample_ready, 1'b0);
    RST = 1'b0;
    model_reset();
    p_chk[0] = 1'b0;
    p_chk[1] = 1'b0;
    prev_vnot = vnotactive;
  endtask

  initial begin
    RST = 1'b1;
    row = '0; col = '0; vnotactive = 1'b0; color = 1'b0;
    up = 1'b1; down = 1'b1; left = 1'b1; right = 1'b1;
    sample_valid = 1'b0; sample_ch = '0; sample_data = '0;
    p_chk[0] = 1'b0; p_chk[1] = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_val("rst_rgb", {red, green, blue}, 3'b111);
    check_val("rst_ready", sample_ready, 1'b0);
    RST = 1'b0;
    prev_vnot = 1'b0;

    // Empty history: everything is background.
    add_dir(265, 552, 3'b111);
    frame(300, 6, 4'hF, 1'b0);

    // Single ch0 sample, offset 65: newest slot (k=63, cols 552..555).
    pend_ch.push_back(2'd0); pend_d.push_back(17'h04100);
    add_dir(265, 552, 3'b100);
    add_dir(275, 555, 3'b100);
    add_dir(264, 552, GRIDC);
    add_dir(276, 552, 3'b111);
    add_dir(270, 556, 3'b111);
    add_dir(270, 551, 3'b111);
    add_dir(270, 301, 3'b111);
    frame(200, 6, 4'hF, 1'b0);

    // DEPTH+3 ch1 samples i<<8: history wraps, oldest visible is i=3.
    for (int i = 0; i < DEPTH + 3; i++) begin
      pend_ch.push_back(2'd1);
      pend_d.push_back(17'(i << 8));
    end
    add_dir(203, 300, 3'b010);
    add_dir(213, 303, 3'b010);
    add_dir(202, 300, GRIDC);
    add_dir(214, 301, 3'b111);
    add_dir(266, 552, 3'b100);
    add_dir(276, 552, 3'b010);
    add_dir(277, 552, 3'b111);
    add_dir(265, 548, 3'b010);
    frame(300, 6, 4'hF, 1'b0);

    // Inverted colours.
    add_dir(266, 552, 3'b011);
    add_dir(100, 100, 3'b000);
    add_dir(203, 301, 3'b101);
    frame(200, 6, 4'hF, 1'b1);

    // Hold up+left for three frames.
    frame(100, 6, 4'b0101, 1'b0);
    frame(100, 6, 4'b0101, 1'b0);
    add_dir(197, 294, 3'b010);
    add_dir(196, 294, GRIDC);
    add_dir(207, 297, 3'b010);
    add_dir(208, 297, 3'b111);
    add_dir(197, 293, 3'b111);
    frame(150, 6, 4'b0101, 1'b0);

    // Up and down together: up wins.
    add_dir(195, 295, 3'b010);
    add_dir(194, 295, 3'b111);
    add_dir(197, 293, 3'b111);
    frame(150, 6, 4'b0011, 1'b0);
    frame(150, 6, 4'b1010, 1'b0);

    // Random traffic: out-of-range channels, random keys and colour mode.
    for (int f = 0; f < 10; f++) begin
      for (int s = 0; s < int'($urandom_range(0, 12)); s++) begin
        pend_ch.push_back(2'($urandom_range(0, 3)));
        pend_d.push_back(17'($urandom_range(0, 17'h9FFF)));
      end
      frame(400, 4 + int'($urandom_range(0, 4)), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of active video clears history and origin.
    frame(60, 6, 4'hF, 1'b0);
    do_reset();
    add_dir(210, 300, GRIDC);
    add_dir(210, 364, GRIDC);
    add_dir(200, 310, GRIDC);
    add_dir(264, 310, GRIDC);
    add_dir(210, 310, 3'b111);
    add_dir(266, 552, 3'b111);
    add_dir(203, 301, 3'b111);
    active_phase(200);
    frame(200, 6, 4'hF, 1'b0);

    blank_phase(4, 4'hF, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
